prom_fetch_ctrl: RTL and testbench
==================================

Name: prom_fetch_ctrl

Overview:
Instruction-fetch sequencer for the program ROM. The ROM is a single read port with registered output, so data appears one cycle after the address.
- Drives the ROM address and absorbs the 1-cycle read latency.
- Buffers fetched words in a small FIFO.
- Presents instructions to the CPU decode stage on a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and discarding the in-flight read.

Parameters:
- WIDTH, `CODE_ADDR_WIDTH: program address width; the ROM holds 2^WIDTH words.
- DEPTH, 2: fetch buffer entries; legal values are 2 and 4.
- RESET_PC, 0: first address fetched after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  WIDTH  address to ROM; ROM returns data on the next edge.
- rom_data  input  16  ROM read data for the address presented in the previous cycle.
- jump_valid  input  1  redirect request from the CPU, one-cycle pulse.
- jump_addr  input  WIDTH  redirect target; sampled when jump_valid=1.
- instr_valid  output  1  instr and instr_pc hold a valid fetched word.
- instr  output  16  instruction word at the FIFO head.
- instr_pc  output  WIDTH  address of instr.
- instr_ready  input  1  consumer accepts the head when instr_valid&instr_ready.

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high, named reset.
- State:
  - fetch_pc (WIDTH bits).
  - inflight bit plus inflight_pc.
  - FIFO of DEPTH entries, each {pc, word}; count is 0..DEPTH.
  - instr_valid, instr and instr_pc are the registered FIFO head.
- Reset values:
  - instr_valid=0, instr=0, instr_pc=0, count=0, inflight=0.
  - fetch_pc=RESET_PC.
  - rom_addr=RESET_PC, held for the whole time reset is asserted.
- pop = instr_valid & instr_ready & ~jump_valid.
- issue = ~reset & (jump_valid | (count + inflight - pop < DEPTH)).
- rom_addr is combinational: jump_addr when jump_valid, else fetch_pc. When not issuing, rom_addr still shows fetch_pc; that read is ignored.
- On issue:
  - inflight<=1, inflight_pc<=rom_addr.
  - fetch_pc<=rom_addr+1, wrapping modulo 2^WIDTH (all-ones wraps to 0).
- On no issue: inflight<=0 and fetch_pc holds.
- Capture: a cycle with inflight=1 and no jump_valid writes {inflight_pc, rom_data} into the FIFO tail.
- Redirect (jump_valid=1) has priority over everything:
  - FIFO flushed (count<=0, instr_valid<=0).
  - The current inflight word is discarded, not written.
  - A simultaneous instr_ready is ignored.
  - The read of jump_addr is issued in the same cycle.
- Latency:
  - Issue cycle N → rom_data in N+1 → instr_valid=1 in N+2.
  - First instr_valid after reset deasserts: 2 cycles.
  - Redirect to target instr_valid: 2 cycles.
- Throughput: with instr_ready held at 1, one instruction per cycle, no bubbles.
- Stall: instr_ready=0 holds instr, instr_pc and instr_valid stable. Issue stops once count+inflight reaches DEPTH, so there is no overflow and no lost word.
- Simultaneous capture and pop: count unchanged, and the head advances to the next entry (or to the captured word if the FIFO held one).
- Boundaries:
  - count never exceeds DEPTH.
  - instr_valid=0 whenever count=0.
  - Back-to-back jump_valid pulses: each aborts the previous redirect, and only the last target's stream appears.
- Reset asserted mid-stream: the next edge returns all state to reset values. In-flight data is dropped and the ROM's output is ignored.

Decomposition:
- Shared package: `CODE_ADDR_WIDTH and `CODE_SIZE (already in constants.svh), plus a new `RESET_PC constant.
- One natural sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO of {pc, word} with push, pop, flush, count and a registered head.
- The controller holds fetch_pc, the inflight tracking and the issue/redirect logic.

Test Plan:
- Reset then instr_ready=1 with ROM[0..3]=1111,2222,3333,4444 → instr_valid rises 2 cycles after reset release, then 1111/pc0, 2222/pc1, 3333/pc2, 4444/pc3 on consecutive cycles.
- instr_ready=0 for 5 cycles after the first valid → instr stays 1111/pc0, count reaches DEPTH, issue stops. On release, words continue in order with none skipped or duplicated.
- jump_valid with jump_addr=0x100 while FIFO full and a read inflight → next cycle instr_valid=0. Two cycles later instr_pc=0x100 with ROM[0x100], and no stale word appears.
- jump_valid and instr_ready in the same cycle, then a second jump to 0x200 one cycle later → only the 0x200 stream is delivered.
- Jump to address 2^WIDTH-1 → delivered pcs are 2^WIDTH-1, then 0, then 1 (wrap-around).
- reset asserted for 1 cycle mid-stream with a read inflight → next cycle all outputs at reset values; the fetch restarts at RESET_PC with the standard 2-cycle latency.

Source files
------------

// File: rtl/prom_fetch_ctrl_pkg.sv
// Shared constants and types for the program-ROM fetch sequencer.
package prom_fetch_ctrl_pkg;

  localparam int CODE_ADDR_WIDTH = 10;
  localparam int CODE_SIZE       = 1 << CODE_ADDR_WIDTH;
  localparam int CODE_RESET_PC   = 0;
  localparam int INSTR_W         = 16;

  typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/prom_fetch_ctrl_if.sv
// ROM port, redirect request and decode-side valid/ready handshake of the fetch unit.
interface prom_fetch_ctrl_if
  import prom_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = CODE_ADDR_WIDTH
);

  logic [WIDTH-1:0] rom_addr;
  instr_t           rom_data;
  logic             jump_valid;
  logic [WIDTH-1:0] jump_addr;
  logic             instr_valid;
  instr_t           instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    input  jump_valid,
    input  jump_addr,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output jump_valid,
    output jump_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/prom_fetch_ctrl_fetch_fifo.sv
// Shift-register FIFO of {pc, word}; entry 0 is the registered head seen by decode.
module prom_fetch_ctrl_fetch_fifo
  import prom_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = CODE_ADDR_WIDTH,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_pc_i,
  input  instr_t           push_word_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             head_valid_o,
  output logic [WIDTH-1:0] head_pc_o,
  output instr_t           head_word_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] pc_q   [DEPTH];
  logic [WIDTH-1:0] pc_d   [DEPTH];
  instr_t           word_q [DEPTH];
  instr_t           word_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;

  // Pop shifts everything toward the head first, so a push lands after the survivors.
  always_comb begin
    pc_d    = pc_q;
    word_d  = word_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (pop_i && count_q != '0) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          pc_d[i]   = pc_q[i+1];
          word_d[i] = word_q[i+1];
        end
        count_d = count_q - 1'b1;
      end
      if (push_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == count_d) begin
            pc_d[i]   = push_pc_i;
            word_d[i] = push_word_i;
          end
        end
        count_d = count_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != '0);
      pc_q    <= pc_d;
      word_q  <= word_d;
    end
  end

  assign head_valid_o = valid_q;
  assign head_pc_o    = pc_q[0];
  assign head_word_o  = word_q[0];
  assign count_o      = count_q;

endmodule

// File: rtl/prom_fetch_ctrl.sv
// Instruction-fetch sequencer: drives the ROM address, tracks the one read in flight
// and buffers returned words for the decode stage; redirects flush and refetch.
module prom_fetch_ctrl
  import prom_fetch_ctrl_pkg::*;
#(
  parameter int               WIDTH    = CODE_ADDR_WIDTH,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(CODE_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  prom_fetch_ctrl_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] rom_addr;
  logic             pop, push, issue;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] count;
  logic             head_valid;
  logic [WIDTH-1:0] head_pc;
  instr_t           head_word;

  // Occupancy counts the buffered words plus the read still in flight, net of this cycle's pop,
  // so issue stops before a returning word could find the buffer full.
  always_comb begin
    rom_addr = fetch_pc_q;
    if (reset) begin
      rom_addr = RESET_PC;
    end else if (bus.jump_valid) begin
      rom_addr = bus.jump_addr;
    end
    pop   = head_valid & bus.instr_ready & ~bus.jump_valid;
    push  = inflight_q & ~bus.jump_valid;
    occ   = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
    issue = ~reset & (bus.jump_valid | (occ < OCC_W'(DEPTH)));

    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    fetch_pc_d    = fetch_pc_q;
    if (issue) begin
      inflight_pc_d = rom_addr;
      fetch_pc_d    = rom_addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
  end

  prom_fetch_ctrl_fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_pc_i    (inflight_pc_q),
    .push_word_i  (bus.rom_data),
    .pop_i        (pop),
    .flush_i      (bus.jump_valid),
    .head_valid_o (head_valid),
    .head_pc_o    (head_pc),
    .head_word_o  (head_word),
    .count_o      (count)
  );

  assign bus.rom_addr    = rom_addr;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_word;
  assign bus.instr_pc    = head_pc;

endmodule

// File: tb/tb_prom_fetch_ctrl.sv
// Bench for prom_fetch_ctrl: directed scenarios plus random traffic against a queue-based reference.
module tb_prom_fetch_ctrl;
  import prom_fetch_ctrl_pkg::*;

  localparam int W = 10;
  localparam int D = 2;
  localparam logic [W-1:0] RPC = '0;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [15:0]  w;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prom_fetch_ctrl_if #(.WIDTH(W)) bus ();

  prom_fetch_ctrl #(
    .WIDTH    (W),
    .DEPTH    (D),
    .RESET_PC (RPC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] rom [0:(1<<W)-1];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int checks = 0;
  int failures = 0;

  // Reference state: words that must be buffered (head first), the outstanding read, next fetch pc.
  ent_t         q[$];
  logic         m_inf = 1'b0;
  logic [W-1:0] m_ipc = '0;
  logic [W-1:0] m_fpc = RPC;
  logic [W-1:0] acc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string nm, input logic [W-1:0] base, input int n);
    if (acc.size() < n) chk({nm, "_len"}, 32'(acc.size()), 32'(n));
    else for (int i = 0; i < n; i++) chk(nm, 32'(acc[i]), 32'(W'(base + W'(i))));
  endtask

  initial begin
    for (int i = 0; i < (1 << W); i++) rom[i] = 16'(i * 40503) ^ 16'h5A5A;
    rom[0] = 16'h1111;
    rom[1] = 16'h2222;
    rom[2] = 16'h3333;
    rom[3] = 16'h4444;
  end

  initial begin : model
    bit pop, iss;
    int occ;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        m_inf = 1'b0;
        m_fpc = RPC;
      end else begin
        pop = (q.size() != 0) && bus.instr_ready && !bus.jump_valid;
        occ = q.size() + int'(m_inf) - int'(pop);
        iss = bus.jump_valid || (occ < D);
        a   = bus.jump_valid ? bus.jump_addr : m_fpc;
        if (bus.jump_valid) q.delete();
        else begin
          if (pop) void'(q.pop_front());
          if (m_inf) q.push_back({m_ipc, rom[m_ipc]});
        end
        m_inf = iss;
        if (iss) begin
          m_ipc = a;
          m_fpc = a + 1'b1;
        end
      end
    end
  end

  initial begin : cmp
    logic [W-1:0] ea;
    forever begin
      @(negedge clk);
      ea = reset ? RPC : (bus.jump_valid ? bus.jump_addr : m_fpc);
      chk("rom_addr", 32'(bus.rom_addr), 32'(ea));
      chk("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("instr", 32'(bus.instr), 32'(q[0].w));
        chk("instr_pc", 32'(bus.instr_pc), 32'(q[0].pc));
      end
      if (!reset && bus.instr_valid && bus.instr_ready && !bus.jump_valid)
        acc.push_back(bus.instr_pc);
    end
  end

  initial begin : drv
    bus.jump_valid  = 1'b0;
    bus.jump_addr   = '0;
    bus.instr_ready = 1'b0;
    reset = 1'b1;

    // Reset values and first-fetch latency
    tick(); tick();
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_pc", 32'(bus.instr_pc), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    tick();
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    #1 chk("first_addr", 32'(bus.rom_addr), 32'd0);
    tick(); chk("lat_valid1", 32'(bus.instr_valid), 32'd0);
    tick(); chk("lat_valid2", 32'(bus.instr_valid), 32'd1);
    chk("w0", 32'(bus.instr), 32'h1111); chk("pc0", 32'(bus.instr_pc), 32'd0);
    tick(); chk("w1", 32'(bus.instr), 32'h2222); chk("pc1", 32'(bus.instr_pc), 32'd1);
    tick(); chk("w2", 32'(bus.instr), 32'h3333); chk("pc2", 32'(bus.instr_pc), 32'd2);
    tick(); chk("w3", 32'(bus.instr), 32'h4444); chk("pc3", 32'(bus.instr_pc), 32'd3);

    // Stall from the first valid word, then resume
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.instr_ready = 1'b0;
    tick(); tick();
    chk("stall_valid", 32'(bus.instr_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_instr", 32'(bus.instr), 32'h1111);
      chk("stall_pc", 32'(bus.instr_pc), 32'd0);
      chk("stall_addr", 32'(bus.rom_addr), 32'd2);
      tick();
    end
    acc.delete();
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check_seq("resume_seq", W'(0), 6);

    // Redirect while the buffer is full
    bus.instr_ready = 1'b0;
    tick(); tick();
    bus.jump_valid = 1'b1;
    bus.jump_addr  = W'(10'h100);
    bus.instr_ready = 1'b1;
    #1 chk("jmp_addr", 32'(bus.rom_addr), 32'h100);
    tick();
    bus.jump_valid = 1'b0;
    chk("jmp_flush", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("jmp_valid", 32'(bus.instr_valid), 32'd1);
    chk("jmp_pc", 32'(bus.instr_pc), 32'h100);
    chk("jmp_word", 32'(bus.instr), 32'(rom[10'h100]));
    tick();
    chk("jmp_pc_next", 32'(bus.instr_pc), 32'h101);

    // Back-to-back redirects with ready asserted
    acc.delete();
    bus.jump_valid = 1'b1;
    bus.jump_addr  = W'(10'h080);
    tick();
    bus.jump_addr  = W'(10'h200);
    tick();
    bus.jump_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check_seq("jj_seq", W'(10'h200), 3);

    // Wrap-around at the top of the address space
    acc.delete();
    bus.jump_valid = 1'b1;
    bus.jump_addr  = W'(10'h3FF);
    tick();
    bus.jump_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check_seq("wrap_seq", W'(10'h3FF), 3);

    // One-cycle reset mid-stream with a read in flight
    reset = 1'b1;
    #1 chk("mid_rst_addr", 32'(bus.rom_addr), 32'(RPC));
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mid_rst_instr", 32'(bus.instr), 32'd0);
    chk("mid_rst_pc", 32'(bus.instr_pc), 32'd0);
    tick(); chk("mid_lat1", 32'(bus.instr_valid), 32'd0);
    tick(); chk("mid_lat2", 32'(bus.instr_valid), 32'd1);
    chk("mid_w0", 32'(bus.instr), 32'h1111);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset           = ($urandom_range(0, 99) < 1);
      bus.instr_ready = ($urandom_range(0, 99) < 70);
      bus.jump_valid  = ($urandom_range(0, 99) < 5);
      bus.jump_addr   = ($urandom_range(0, 3) == 0) ? W'(10'h3FE + 10'($urandom_range(0, 1)))
                                                    : W'($urandom_range(0, (1 << W) - 1));
    end
    tick();
    reset = 1'b0;
    bus.jump_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
